// File: rtl/img_word_packer_pkg.sv
// Shared types and constants for the 28x28 image word packer.
// The FSM state encoding doubles as the oState debug value.
package img_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam int NUM_PIX   = 784;
    localparam int PIX_W     = 8;
    localparam int LANES     = 32;
    localparam int NUM_WORDS = (NUM_PIX + LANES - 1) / LANES;
    localparam int LAST_LANE = (NUM_PIX - 1) % LANES;
    localparam int WORD_W    = LANES * PIX_W;

endpackage

// File: rtl/img_lane_assembler.sv
// Collects 8-bit pixels into a 32-lane word, lane 0 in the LSBs.
// word/word_done present the completed word in the same cycle its final pixel arrives.
module img_lane_assembler
    import img_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              accept,
    input  logic              flush,
    input  logic [PIX_W-1:0]  pix,
    output logic [WORD_W-1:0] word,
    output logic              word_done
);

    localparam int LANE_W = $clog2(LANES);

    logic [LANES-1:0][PIX_W-1:0] lanes_r;
    logic [LANE_W-1:0]           lane_r;
    logic [LANES-1:0][PIX_W-1:0] asm_s;

    // Merge the incoming pixel so a full word is visible without waiting a cycle
    always_comb begin
        asm_s         = lanes_r;
        asm_s[lane_r] = pix;
        word          = asm_s;
        word_done     = accept && ((lane_r == LANE_W'(LANES - 1)) || flush);
    end

    // Lane storage; cleared after each completed word so a flushed word has zero upper lanes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lanes_r <= '0;
            lane_r  <= '0;
        end else if (clear) begin
            lanes_r <= '0;
            lane_r  <= '0;
        end else if (accept) begin
            if (word_done) begin
                lanes_r <= '0;
                lane_r  <= '0;
            end else begin
                lanes_r[lane_r] <= pix;
                lane_r          <= lane_r + LANE_W'(1);
            end
        end else begin
            lanes_r <= lanes_r;
            lane_r  <= lane_r;
        end
    end

endmodule

// File: rtl/img_word_packer.sv
// Captures one 784-pixel frame on CPU request, quantises to 8 bits and writes
// 25 packed 256-bit words to data memory, then signals done.
module img_word_packer
    import img_pkg::*;
#(
    parameter int ADDR_W    = 7,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              iEnable,
    output logic              oDone,
    input  logic              iFVAL,
    input  logic              iDVAL,
    input  logic [11:0]       iDATA,
    output logic              oDmem_wren,
    output logic [ADDR_W-1:0] oDmem_addr,
    output logic [WORD_W-1:0] oDmem_data,
    output logic [1:0]        oState,
    output logic [9:0]        oPix_cnt
);

    localparam int WIDX_W = $clog2(NUM_WORDS);

    state_t              state_r, state_next_s;
    logic                seen_low_r;
    logic [9:0]          pix_cnt_r;
    logic [WIDX_W-1:0]   word_idx_r;
    logic                wren_r, done_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [WORD_W-1:0]   data_r;
    logic                accept_s, last_s, clear_s;
    logic [WORD_W-1:0]   word_s;
    logic                word_done_s;
    logic                unused_low_bits_s;

    assign unused_low_bits_s = ^iDATA[3:0];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; a completing last pixel wins over a same-cycle iFVAL fall
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE:    state_next_s = iEnable ? ARM : IDLE;
            ARM: begin
                if (!iEnable)                  state_next_s = IDLE;
                else if (seen_low_r && iFVAL)  state_next_s = CAPTURE;
                else                           state_next_s = ARM;
            end
            CAPTURE: begin
                if (!iEnable)                  state_next_s = IDLE;
                else if (accept_s && last_s)   state_next_s = DONE;
                else if (!iFVAL)               state_next_s = ARM;
                else                           state_next_s = CAPTURE;
            end
            DONE:    state_next_s = iEnable ? DONE : IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Datapath control decoded from the current state
    always_comb begin
        accept_s = (state_r == CAPTURE) && iEnable && iDVAL && (pix_cnt_r != 10'(NUM_PIX));
        last_s   = (pix_cnt_r == 10'(NUM_PIX - 1));
        clear_s  = (state_r != CAPTURE);
    end

    img_lane_assembler u_asm (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear_s),
        .accept    (accept_s),
        .flush     (last_s),
        .pix       (iDATA[11:4]),
        .word      (word_s),
        .word_done (word_done_s)
    );

    // Frame tracking: low-seen flag for ARM, pixel and word counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen_low_r <= 1'b0;
            pix_cnt_r  <= 10'd0;
            word_idx_r <= '0;
        end else begin
            seen_low_r <= (state_r == ARM) ? (seen_low_r | ~iFVAL) : 1'b0;
            if ((state_next_s == IDLE) || (state_next_s == ARM)) begin
                pix_cnt_r <= 10'd0;
            end else if (accept_s) begin
                pix_cnt_r <= pix_cnt_r + 10'd1;
            end else begin
                pix_cnt_r <= pix_cnt_r;
            end
            if (clear_s) begin
                word_idx_r <= '0;
            end else if (word_done_s) begin
                word_idx_r <= word_idx_r + WIDX_W'(1);
            end else begin
                word_idx_r <= word_idx_r;
            end
        end
    end

    // Output register, decoupled from assembly so back-to-back pixels never stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wren_r <= 1'b0;
            addr_r <= '0;
            data_r <= '0;
            done_r <= 1'b0;
        end else begin
            wren_r <= word_done_s;
            done_r <= (state_next_s == DONE);
            if (word_done_s) begin
                addr_r <= ADDR_W'(BASE_ADDR) + ADDR_W'(word_idx_r);
                data_r <= word_s;
            end else begin
                addr_r <= addr_r;
                data_r <= data_r;
            end
        end
    end

    assign oDmem_wren = wren_r;
    assign oDmem_addr = addr_r;
    assign oDmem_data = data_r;
    assign oDone      = done_r;
    assign oState     = state_r;
    assign oPix_cnt   = pix_cnt_r;

endmodule

// File: doc/img_word_packer.md
Name: img_word_packer

Overview:
Downstream stage of the 28x28 crop/downsample pipeline. It takes the 12-bit grayscale pixel stream, under control of a CPU enable/done handshake, captures exactly one full frame. It quantises each pixel to 8 bits and packs 32 pixels per 256-bit word. Each completed word is written through the data-memory 256-bit write port, so the NN core reads the image as 25 consecutive words.

Parameters:
NUM_PIX, 784, pixels per captured frame (28x28)
PIX_W, 8, stored bits per pixel (upper bits of 12-bit input)
WORD_W, 256, DMEM word width; lanes per word = WORD_W/PIX_W = 32
ADDR_W, 7, DMEM address width
BASE_ADDR, 0, DMEM address of word 0

Ports:
clk  input  1  pixel-domain clock; all inputs synchronous to it
rst_n  input  1  asynchronous active-low reset
iEnable  input  1  CPU capture request, level
oDone  output  1  frame stored, held until iEnable drops
iFVAL  input  1  frame valid, already synchronised to clk
iDVAL  input  1  pixel valid strobe, may be high every cycle
iDATA  input  12  grayscale pixel
oDmem_wren  output  1  one-cycle write strobe
oDmem_addr  output  ADDR_W  write address
oDmem_data  output  WORD_W  write data
oState  output  2  current FSM state (debug)
oPix_cnt  output  10  pixels accepted in current frame

Behaviour:
- Reset (async, rst_n=0): state IDLE, oDone=0, oDmem_wren=0, oDmem_addr=0, oDmem_data=0, oPix_cnt=0, lane shift register cleared.
- States, oState encoding: IDLE=0, ARM=1, CAPTURE=2, DONE=3.
- IDLE: when iEnable=1 go to ARM; clear counters.
- ARM: wait until iFVAL has been sampled low at least once, then rising edge of iFVAL (low->high between consecutive cycles) -> CAPTURE. A frame already in progress at enable is never captured.
- CAPTURE: each cycle with iDVAL=1 accepts pixel p = iDATA[11:4]. Pixel index k (0..783) lands at lane k mod 32, bits [8*lane+7 : 8*lane], so lane 0 is LSBs.
- Word write: when lane 31 is accepted in cycle N, cycle N+1 drives oDmem_wren=1, oDmem_addr=BASE_ADDR+word_idx, oDmem_data=completed word. The output register is separate from the assembly register, so back-to-back iDVAL loses no pixel.
- Last word: pixel 783 is lane 15 of word 24. On its acceptance in cycle N, cycle N+1 writes word 24 with lanes 16..31 = 0. The FSM then goes to DONE.
- Address arithmetic: word_idx is 0..24. oDmem_addr wraps modulo 2^ADDR_W and is not saturated.
- DONE: oDone=1 and no writes. When iEnable=0, go to IDLE and oDone=0 the next cycle.
- iDVAL is ignored outside CAPTURE. Pixels beyond 784 in the same frame are ignored.
- Short frame: iFVAL falls in CAPTURE before 784 pixels are accepted. No flush of the partial word; counters clear; return to ARM. The next frame overwrites from word 0; oDone stays 0.
- iEnable drops in ARM or CAPTURE: abort to IDLE next cycle. No further writes; partial word discarded.
- Simultaneous iDVAL and iFVAL falling edge: the pixel is accepted first; if it was pixel 783 the frame completes normally.
- oPix_cnt increments on each accepted pixel, saturates at 784, and clears on entry to ARM or IDLE.

Decomposition:
- Shared package img_pkg: state enum typedef (IDLE/ARM/CAPTURE/DONE), constants NUM_PIX, LANES=32, NUM_WORDS=25, LAST_LANE=15.
- One sub-module, img_lane_assembler: 32x8 lane register with lane counter and word-complete pulse.
- FSM, address counter and output register stay in img_word_packer.

Test Plan:
- Reset mid-CAPTURE after 40 pixels -> all outputs 0 immediately. After release with iEnable=1, state goes to ARM with no write issued.
- iEnable=1, one frame of 784 pixels with iDVAL every cycle, pixel k = (k mod 256)<<4 -> 25 writes at addr 0..24. Word 0 = bytes 0..31 ascending from LSB. Word 24 lanes 0..15 = 0x00..0x0F, lanes 16..31 = 0. oDone=1; oPix_cnt=784.
- iFVAL already high when iEnable rises -> no write until iFVAL goes low then high. The capture then matches the previous scenario.
- Short frame: iFVAL drops after 100 pixels -> 3 writes (addr 0..2), then state ARM and oDone=0. The next full frame writes addr 0..24 and sets oDone.
- iDVAL with random gaps plus 50 extra pixels after pixel 783 -> exactly 25 writes. Data is identical to the gapless case and extra pixels are ignored.
- iEnable drops at pixel 500 -> state IDLE, no write for word 15. Re-enable restarts from ARM and addr 0.
